// File: rtl/or_sched_pkg.sv
// Shared types and default sizing for the OR datapath scheduler.
package or_sched_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;
  localparam int unsigned OR_WIDTH_DEF = 8;

  // Scheduler FSM: grant in IDLE, one-cycle datapath pass in EXEC, hold result in RESP
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/or_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - highest-priority index this round
//   gnt  - one-hot grant (all zero when no request)
//   idx  - binary index of the granted requester
//   any  - at least one request present
module or_rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Scan NUM_REQ positions starting at ptr; first hit wins
  always_comb begin
    int unsigned k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      k = (32'(ptr) + off) % NUM_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/or_rr_scheduler.sv
// Round-robin scheduler sharing one OR datapath among NUM_REQ requesters.
// One operation in flight; the result returns tagged with the requester index.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   req_valid/req_ready  - per-requester handshake, ready is one-hot and only in IDLE
//   req_a/req_b          - packed operands, slice i belongs to requester i
//   or_a/or_b            - registered operands to the OR datapath
//   or_y                 - datapath result (combinational from or_a/or_b)
//   rsp_valid/rsp_ready  - result handshake
//   rsp_y/rsp_id         - registered result and owning requester index
module or_rr_scheduler
  import or_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter  int unsigned OR_WIDTH = OR_WIDTH_DEF,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*OR_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*OR_WIDTH-1:0] req_b,
  output logic [OR_WIDTH-1:0]         or_a,
  output logic [OR_WIDTH-1:0]         or_b,
  input  logic [OR_WIDTH-1:0]         or_y,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [OR_WIDTH-1:0]         rsp_y,
  output logic [ID_W-1:0]             rsp_id
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [OR_WIDTH-1:0] or_a_d, or_b_d;
  logic                rsp_valid_d;
  logic [OR_WIDTH-1:0] rsp_y_d;
  logic [ID_W-1:0]     rsp_id_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  or_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Accept only while idle; held low during reset so no grant is visible then
  assign req_ready = (state_q == IDLE && !rst) ? pick_gnt : '0;

  // State register and datapath/result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      or_a      <= '0;
      or_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      or_a      <= or_a_d;
      or_b      <= or_b_d;
      rsp_valid <= rsp_valid_d;
      rsp_y     <= rsp_y_d;
      rsp_id    <= rsp_id_d;
    end
  end

  // Next-state and next register values; everything holds by default
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    or_a_d      = or_a;
    or_b_d      = or_b;
    rsp_valid_d = rsp_valid;
    rsp_y_d     = rsp_y;
    rsp_id_d    = rsp_id;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          or_a_d  = req_a[32'(pick_idx)*OR_WIDTH +: OR_WIDTH];
          or_b_d  = req_b[32'(pick_idx)*OR_WIDTH +: OR_WIDTH];
          id_d    = pick_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_y_d     = or_y;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Priority moves just past the requester served, giving starvation freedom
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_or_rr_scheduler.sv
module tb_or_rr_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main build: 4 requesters x 8 bits
  logic [N-1:0]        req_valid, req_ready;
  logic [N-1:0][W-1:0] ra, rb;
  logic [W-1:0]        or_a, or_b, or_y;
  logic                rsp_valid, rsp_ready;
  logic [W-1:0]        rsp_y;
  logic [IW-1:0]       rsp_id;

  assign or_y = or_a | or_b;

  or_rr_scheduler #(.NUM_REQ(N), .OR_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(ra), .req_b(rb),
    .or_a(or_a), .or_b(or_b), .or_y(or_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id)
  );

  // Narrow build: 2 requesters x 1 bit
  logic [1:0] s_req_valid, s_req_ready, s_ra, s_rb;
  logic       s_or_a, s_or_b, s_or_y;
  logic       s_rsp_valid, s_rsp_ready, s_rsp_y;
  logic       s_rsp_id;

  assign s_or_y = s_or_a | s_or_b;

  or_rr_scheduler #(.NUM_REQ(2), .OR_WIDTH(1)) dut_s (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a(s_ra), .req_b(s_rb),
    .or_a(s_or_a), .or_b(s_or_b), .or_y(s_or_y),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_y(s_rsp_y), .rsp_id(s_rsp_id)
  );

  typedef struct {
    int id;
    int y;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int   grants[$];
  int   rsp_cyc[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   mptr    = 0;
  logic prev_rv = 1'b0;
  logic [N-1:0]        pend_v = '0;
  logic [N-1:0][W-1:0] pend_a, pend_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference arbiter: first valid at or after p, wrapping
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int off = 0; off < int'(N); off++)
      if (v[(p + off) % int'(N)]) return (p + off) % int'(N);
    return -1;
  endfunction

  // One clock: sample at negedge, score handshakes, return at posedge+1
  task automatic step();
    int g;
    logic [N-1:0] expr;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < int'(N); i++)
      if (pend_v[i])
        assert (req_valid[i] && ra[i] == pend_a[i] && rb[i] == pend_b[i])
          else $error("protocol violation by requester %0d", i);
    expr = '0;
    if (q.size() == 0) begin
      g = pick(req_valid, mptr);
      if (g >= 0) expr[g] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(expr));
    for (int i = 0; i < int'(N); i++)
      if (req_valid[i] && req_ready[i]) begin
        q.push_back('{id: i, y: int'(ra[i] | rb[i])});
        grants.push_back(i);
        acc_cyc = cyc;
      end
    pend_v = req_valid & ~req_ready;
    pend_a = ra;
    pend_b = rb;
    if (rsp_valid) begin
      chk("rsp_pending", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) begin
        chk("rsp_y", 32'(rsp_y), 32'(q[0].y));
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        if (!prev_rv) chk("latency", 32'(cyc - acc_cyc), 32'(2));
        if (rsp_ready) begin
          rsp_cyc.push_back(cyc);
          mptr = (q[0].id + 1) % int'(N);
          void'(q.pop_front());
        end
      end
    end
    prev_rv = rsp_valid;
    for (int i = 0; i < 2; i++)
      if (s_req_valid[i] && s_req_ready[i])
        q2.push_back('{id: i, y: int'(s_ra[i] | s_rb[i])});
    if (s_rsp_valid && s_rsp_ready) begin
      chk("s_rsp_pending", 32'(q2.size() != 0), 32'(1));
      if (q2.size() != 0) begin
        chk("s_rsp_y", 32'(s_rsp_y), 32'(q2[0].y));
        chk("s_rsp_id", 32'(s_rsp_id), 32'(q2[0].id));
        void'(q2.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drain outstanding work within a cycle budget
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(q.size() + q2.size()), 32'(0));
  endtask

  // Assert reset mid-cycle, check outputs cleared immediately, release after an edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_or_a", 32'(or_a), 32'(0));
    chk("rst_or_b", 32'(or_b), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_y", 32'(rsp_y), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_s_rsp_valid", 32'(s_rsp_valid), 32'(0));
    q.delete();
    q2.delete();
    mptr    = 0;
    prev_rv = 1'b0;
    pend_v  = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n;
    int g0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    req_valid = '0; ra = '0; rb = '0; rsp_ready = 1'b1;
    s_req_valid = '0; s_ra = '0; s_rb = '0; s_rsp_ready = 1'b1;
    do_reset();

    // 1: single requester, 0x0F | 0xF0
    req_valid = 4'b0001; ra[0] = 8'h0F; rb[0] = 8'hF0;
    step();
    chk("t1_accept", 32'(grants.size()), 32'(1));
    req_valid = '0;
    wait_done(10);

    // 2: all requesters streaming
    do_reset();
    grants.delete(); rsp_cyc.delete();
    ra = {8'h80, 8'h04, 8'h20, 8'h01};
    rb = {8'h08, 8'h40, 8'h02, 8'h10};
    req_valid = 4'b1111;
    n = 0;
    while (rsp_cyc.size() < 5 && n < 60) begin
      step();
      n++;
    end
    chk("t2_grants", 32'(grants.size()), 32'(5));
    for (int i = 0; i < grants.size() && i < 5; i++)
      chk("t2_order", 32'(grants[i]), 32'(exp_order[i]));
    chk("t2_rsps", 32'(rsp_cyc.size()), 32'(5));
    for (int i = 1; i < rsp_cyc.size(); i++)
      chk("t2_period", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'(3));
    req_valid = '0;
    do_reset();

    // 3: response stall with another requester waiting
    grants.delete();
    req_valid = 4'b0100; ra[2] = 8'hA0; rb[2] = 8'h05;
    step();
    chk("t3_accept", 32'(grants.size()), 32'(1));
    req_valid = 4'b0001; ra[0] = 8'h11; rb[0] = 8'h22;
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    repeat (5) step();
    chk("t3_held", 32'(q.size()), 32'(1));

    // 4: pointer past requester 2, so 0 wins over 2
    rsp_ready = 1'b1;
    g0 = grants.size();
    ra[2] = 8'h0C; rb[2] = 8'h30;
    req_valid = 4'b0101;
    n = 0;
    while (grants.size() < g0 + 1 && n < 10) begin
      step();
      n++;
    end
    req_valid[0] = 1'b0;
    n = 0;
    while (grants.size() < g0 + 2 && n < 10) begin
      step();
      n++;
    end
    req_valid = '0;
    wait_done(10);
    chk("t4_grants", 32'(grants.size()), 32'(g0 + 2));
    if (grants.size() >= g0 + 2) begin
      chk("t4_first", 32'(grants[g0]), 32'(0));
      chk("t4_second", 32'(grants[g0+1]), 32'(2));
    end

    // 5: reset during EXEC drops the op; then requester 2 alone
    req_valid = 4'b0010; ra[1] = 8'h41; rb[1] = 8'h18;
    g0 = grants.size();
    step();
    chk("t5_accept", 32'(grants.size()), 32'(g0 + 1));
    req_valid = 4'b0100; ra[2] = 8'h05; rb[2] = 8'h80;
    do_reset();
    g0 = grants.size();
    n = 0;
    while (grants.size() < g0 + 1 && n < 10) begin
      step();
      n++;
    end
    req_valid = '0;
    wait_done(10);
    chk("t5_grant", 32'(grants.size()), 32'(g0 + 1));
    if (grants.size() == g0 + 1) chk("t5_id", 32'(grants[g0]), 32'(2));

    // 6: 1-bit, 2-requester build
    s_req_valid = 2'b01; s_ra = 2'b01; s_rb = 2'b00;
    step();
    chk("t6_accept0", 32'(q2.size()), 32'(1));
    s_req_valid = '0;
    wait_done(10);
    s_req_valid = 2'b10; s_ra = 2'b00; s_rb = 2'b00;
    step();
    chk("t6_accept1", 32'(q2.size()), 32'(1));
    s_req_valid = '0;
    wait_done(10);
    s_req_valid = 2'b01; s_ra = 2'b00; s_rb = 2'b01;
    step();
    chk("t6_accept2", 32'(q2.size()), 32'(1));
    s_req_valid = '0;
    wait_done(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
